crossing_phase_sequencer: RTL and testbench
===========================================

// Module: crossing_phase_sequencer
// PURPOSE
// - Upstream phase generator for the light-decode stage. Replaces the free-running 3-bit
//   light counter with a timed, request-driven two-road sequencer.
// - Drives main road A (red/yellow/green) and side road B (red2/yellow2/green2).
// - German sequence: RED -> RED+YELLOW -> GREEN -> YELLOW -> all-red clearance.
// - Supports side-road request latching and night-mode blinking yellow.
// PARAMETERS
// - CNT_W        5  width of the dwell counter; every T_* must be < 2**CNT_W
// - T_ALLRED     1  ticks in each all-red clearance state
// - T_RY         1  ticks in RED+YELLOW
// - T_YELLOW     2  ticks in YELLOW
// - T_GREEN_MIN  4  minimum green ticks, both roads
// - T_GREEN_MAX 16  maximum B green ticks while req_b is held
// - T_BLINK      2  ticks per yellow on/off half-period in night mode
// PORTS
// - clk          in   1  single clock, all logic on posedge
// - rst          in   1  synchronous reset, active-high
// - tick         in   1  advance enable; timers count only on cycles with tick=1
// - req_b        in   1  side-road vehicle/pedestrian request (level or 1-cycle pulse)
// - night        in   1  night-mode request (level)
// - red,yellow,green      out 1 each  road A lamps, registered
// - red2,yellow2,green2   out 1 each  road B lamps, registered
// - phase        out  4  current state code
// - req_pending  out  1  latched B request, registered
// BEHAVIOUR
// - Reset: state=ALL_RED_A, dwell=0, red=red2=1, all other lamps 0, phase=0, req_pending=0.
//   rst takes effect in the cycle it is sampled, in any state including mid-phase or NIGHT.
// - States and codes: ALL_RED_A=0, A_RY=1, A_G=2, A_Y=3, ALL_RED_B=4, B_RY=5, B_G=6, B_Y=7,
//   NIGHT=8.
// - Transitions are evaluated only on tick=1. dwell counts ticks spent in the state.
//   - dwell resets to 0 on every state change.
//   - dwell saturates at 2**CNT_W-1, with no wrap.
// - Exit conditions (on a tick):
//   - ALL_RED_A: dwell==T_ALLRED-1 -> NIGHT if night=1, else A_RY.
//   - A_RY: dwell==T_RY-1 -> A_G.
//   - A_G: dwell>=T_GREEN_MIN-1 && req_pending -> A_Y.
//     Without a request, A_G holds indefinitely.
//   - A_Y: dwell==T_YELLOW-1 -> ALL_RED_B.
//   - ALL_RED_B: dwell==T_ALLRED-1 -> NIGHT if night=1, else B_RY.
//   - B_RY: dwell==T_RY-1 -> B_G.
//   - B_G: exits when dwell>=T_GREEN_MIN-1 && !req_b, or when dwell==T_GREEN_MAX-1.
//     Either way the next state is B_Y.
//   - B_Y: dwell==T_YELLOW-1 -> ALL_RED_A.
//   - NIGHT: night=0 -> ALL_RED_A.
// - night is honoured only at the end of an all-red state. A green phase is never aborted.
// - req_pending:
//   - Set by req_b=1 on any clk edge, tick not required.
//   - Cleared on entry to B_RY.
//   - Set and clear in the same cycle: the clear wins.
//   - Requests in B_RY, B_G and B_Y are not latched; req_b in B_G only extends the green.
// - Lamp decode, a function of state:
//   - ALL_RED_*: red=red2=1.
//   - A_RY: red=yellow=1, red2=1.  A_G: green=1, red2=1.  A_Y: yellow=1, red2=1.
//   - B_RY, B_G, B_Y mirror the A states onto the *2 lamps, with red=1.
//   - NIGHT: reds off; yellow=yellow2=blink, with blink toggling every T_BLINK ticks.
//     blink=1 on NIGHT entry.
// - Latency: lamps and phase are registered from the next-state value. They change on the
//   same clk edge that samples the deciding tick.
// - Invariants, which must never be violated:
//   - green & green2 == 0.
//   - green=1 implies red2=1; green2=1 implies red=1.
//   - Exactly one lamp set is legal per state code.
// - tick=0: state, dwell and blink hold; req_pending may still set.
// STRUCTURE
// - Shared include crossing_defs.vh: state code localparams (0-8) and the lamp-vector
//   constants {r,y,g,r2,y2,g2} per state, for reuse by the decode stage and by benches.
// - One sub-module, dwell_timer #(CNT_W):
//   - inputs: clk, rst, tick, clr.
//   - output: count.
//   - behaviour: saturating, clear wins over increment.
// - The top holds the FSM, request latch, blink flop and lamp registers.
// TESTING (defaults, tick=1 every cycle unless stated)
// - Reset release, no req:
//   - ALL_RED_A for 1 cycle, then A_RY for 1 cycle.
//   - Then A_G with green=1, red2=1; phase=2 is held for at least 50 cycles.
// - req_b pulsed 1 cycle during A_G dwell=1:
//   - req_pending=1 on the next edge.
//   - A_G exits at dwell 3, followed by A_Y x2, ALL_RED_B x1 and B_RY.
//   - req_pending=0 on B_RY entry.
// - req_b held high through B_G: B_G lasts exactly 16 ticks.
//   req_b dropped at B_G dwell 2: B_G lasts exactly 4 ticks.
// - night=1 asserted in A_G (with req): A_G, A_Y and ALL_RED_B complete, then NIGHT.
//   - In NIGHT, yellow=yellow2 follow the pattern 1,1,0,0,1,1 and all reds are 0.
//   - night=0 -> ALL_RED_A next.
// - tick every 3rd cycle: all dwell times scale exactly x3.
//   Assert rst in the middle of B_G: next edge gives phase=0, red=red2=1, others 0.
// - Randomized req_b/night/tick for 10k cycles: check both invariants on every cycle.

Source files
------------

// File: rtl/crossing_phase_sequencer_pkg.sv
// State codes and lamp vectors {r,y,g,r2,y2,g2} for the two-road crossing sequencer,
// shared by the sequencer, the light-decode stage and benches.
package crossing_phase_sequencer_pkg;

   typedef enum logic [3:0] {
      ALL_RED_A = 4'd0,
      A_RY      = 4'd1,
      A_G       = 4'd2,
      A_Y       = 4'd3,
      ALL_RED_B = 4'd4,
      B_RY      = 4'd5,
      B_G       = 4'd6,
      B_Y       = 4'd7,
      NIGHT     = 4'd8
   } state_t;

   localparam logic [5:0] LAMP_ALL_RED = 6'b100_100;
   localparam logic [5:0] LAMP_A_RY    = 6'b110_100;
   localparam logic [5:0] LAMP_A_G     = 6'b001_100;
   localparam logic [5:0] LAMP_A_Y     = 6'b010_100;
   localparam logic [5:0] LAMP_B_RY    = 6'b100_110;
   localparam logic [5:0] LAMP_B_G     = 6'b100_001;
   localparam logic [5:0] LAMP_B_Y     = 6'b100_010;

   function automatic logic [5:0] lamp_decode(input state_t s, input logic blink);
      logic [5:0] v;
      v = LAMP_ALL_RED;
      case (s)
         A_RY:    v = LAMP_A_RY;
         A_G:     v = LAMP_A_G;
         A_Y:     v = LAMP_A_Y;
         B_RY:    v = LAMP_B_RY;
         B_G:     v = LAMP_B_G;
         B_Y:     v = LAMP_B_Y;
         NIGHT:   v = {1'b0, blink, 1'b0, 1'b0, blink, 1'b0};
         default: v = LAMP_ALL_RED;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating tick counter for time spent in the current phase.
// One-cycle latency; clr has priority over increment.
module dwell_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (tick && count != CNT_MAX) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/crossing_phase_sequencer.sv
// Timed, request-driven two-road traffic-light sequencer with night-mode blinking yellow.
// Lamps and phase are registered from the next-state value (same edge as the deciding tick).
module crossing_phase_sequencer
   import crossing_phase_sequencer_pkg::*;
#(
   parameter int CNT_W       = 5,
   parameter int T_ALLRED    = 1,
   parameter int T_RY        = 1,
   parameter int T_YELLOW    = 2,
   parameter int T_GREEN_MIN = 4,
   parameter int T_GREEN_MAX = 16,
   parameter int T_BLINK     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       req_b,
   input  logic       night,
   output logic       red,
   output logic       yellow,
   output logic       green,
   output logic       red2,
   output logic       yellow2,
   output logic       green2,
   output logic [3:0] phase,
   output logic       req_pending
);

   localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(T_ALLRED - 1);
   localparam logic [CNT_W-1:0] RY_END     = CNT_W'(T_RY - 1);
   localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(T_YELLOW - 1);
   localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(T_GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(T_GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] BLINK_END  = CNT_W'(T_BLINK - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] dwell;
   logic             clr;
   logic             blink, blink_nxt;
   logic [CNT_W-1:0] blink_cnt, blink_cnt_nxt;
   logic             req_nxt;
   logic [5:0]       lamps, lamps_nxt;

   dwell_timer #(.CNT_W(CNT_W)) u_dwell (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .clr   (clr),
      .count (dwell)
   );

   always_comb begin
      state_nxt = state;
      if (tick) begin
         unique case (state)
            ALL_RED_A: if (dwell == ALLRED_END) state_nxt = night ? NIGHT : A_RY;
            A_RY:      if (dwell == RY_END)     state_nxt = A_G;
            A_G:       if (dwell >= GMIN_END && req_pending) state_nxt = A_Y;
            A_Y:       if (dwell == YELLOW_END) state_nxt = ALL_RED_B;
            ALL_RED_B: if (dwell == ALLRED_END) state_nxt = night ? NIGHT : B_RY;
            B_RY:      if (dwell == RY_END)     state_nxt = B_G;
            B_G:       if ((dwell >= GMIN_END && !req_b) || dwell == GMAX_END) state_nxt = B_Y;
            B_Y:       if (dwell == YELLOW_END) state_nxt = ALL_RED_A;
            NIGHT:     if (!night)              state_nxt = ALL_RED_A;
            default:   state_nxt = ALL_RED_A;
         endcase
      end
   end

   assign clr = (state_nxt != state);

   always_comb begin
      blink_nxt     = blink;
      blink_cnt_nxt = blink_cnt;
      if (state_nxt == NIGHT && state != NIGHT) begin
         blink_nxt     = 1'b1;
         blink_cnt_nxt = '0;
      end else if (tick && state == NIGHT) begin
         if (blink_cnt == BLINK_END) begin
            blink_nxt     = ~blink;
            blink_cnt_nxt = '0;
         end else begin
            blink_cnt_nxt = blink_cnt + CNT_W'(1);
         end
      end
   end

   // Entry to B_RY serves the request; B-side requests only stretch the B green.
   always_comb begin
      req_nxt = req_pending;
      if (state_nxt == B_RY && state != B_RY) begin
         req_nxt = 1'b0;
      end else if (req_b && !(state inside {B_RY, B_G, B_Y})) begin
         req_nxt = 1'b1;
      end
   end

   assign lamps_nxt = lamp_decode(state_nxt, blink_nxt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ALL_RED_A;
         blink       <= 1'b1;
         blink_cnt   <= '0;
         req_pending <= 1'b0;
         lamps       <= LAMP_ALL_RED;
      end else begin
         state       <= state_nxt;
         blink       <= blink_nxt;
         blink_cnt   <= blink_cnt_nxt;
         req_pending <= req_nxt;
         lamps       <= lamps_nxt;
      end
   end

   assign phase = state;
   assign {red, yellow, green, red2, yellow2, green2} = lamps;

endmodule

// File: tb/tb_crossing_phase_sequencer.sv
// Bench for crossing_phase_sequencer: reference model feeds a scoreboard every cycle,
// plus directed phase-length and night-pattern checks and per-cycle lamp invariants.
module tb_crossing_phase_sequencer;

   localparam int T_ALLRED    = 1;
   localparam int T_RY        = 1;
   localparam int T_YELLOW    = 2;
   localparam int T_GREEN_MIN = 4;
   localparam int T_GREEN_MAX = 16;
   localparam int T_BLINK     = 2;
   localparam int DWELL_MAX   = 31;

   logic       clk = 1'b0;
   logic       rst, tick, req_b, night;
   logic       red, yellow, green, red2, yellow2, green2;
   logic [3:0] phase;
   logic       req_pending;
   logic [5:0] lamps_obs;

   assign lamps_obs = {red, yellow, green, red2, yellow2, green2};

   always #5 clk = ~clk;

   crossing_phase_sequencer #(
      .CNT_W(5), .T_ALLRED(T_ALLRED), .T_RY(T_RY), .T_YELLOW(T_YELLOW),
      .T_GREEN_MIN(T_GREEN_MIN), .T_GREEN_MAX(T_GREEN_MAX), .T_BLINK(T_BLINK)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .req_b(req_b), .night(night),
      .red(red), .yellow(yellow), .green(green),
      .red2(red2), .yellow2(yellow2), .green2(green2),
      .phase(phase), .req_pending(req_pending)
   );

   typedef struct packed {
      logic [3:0] ph;
      logic [5:0] lm;
      logic       rq;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   bit   div3     = 1'b0;

   int m_state, m_dwell, m_bcnt;
   bit m_blink, m_req;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [5:0] tb_lamps(input int s, input bit b);
      case (s)
         1:       return 6'b110_100;
         2:       return 6'b001_100;
         3:       return 6'b010_100;
         5:       return 6'b100_110;
         6:       return 6'b100_001;
         7:       return 6'b100_010;
         8:       return {1'b0, b, 1'b0, 1'b0, b, 1'b0};
         default: return 6'b100_100;
      endcase
   endfunction

   // Reference model: advances on the inputs about to be sampled and queues the expected outputs.
   task automatic model_step();
      int nx;
      exp_t e;
      if (rst) begin
         m_state = 0; m_dwell = 0; m_blink = 1; m_bcnt = 0; m_req = 0;
      end else begin
         nx = m_state;
         if (tick) begin
            case (m_state)
               0: if (m_dwell + 1 == T_ALLRED) nx = night ? 8 : 1;
               1: if (m_dwell + 1 == T_RY) nx = 2;
               2: if (m_req && m_dwell + 1 >= T_GREEN_MIN) nx = 3;
               3: if (m_dwell + 1 == T_YELLOW) nx = 4;
               4: if (m_dwell + 1 == T_ALLRED) nx = night ? 8 : 5;
               5: if (m_dwell + 1 == T_RY) nx = 6;
               6: if ((m_dwell + 1 >= T_GREEN_MIN && !req_b) || m_dwell + 1 == T_GREEN_MAX) nx = 7;
               7: if (m_dwell + 1 == T_YELLOW) nx = 0;
               8: if (!night) nx = 0;
               default: nx = 0;
            endcase
         end
         if (nx == 5 && m_state != 5) m_req = 0;
         else if (req_b && !(m_state inside {5, 6, 7})) m_req = 1;
         if (nx != m_state) begin
            m_dwell = 0;
            if (nx == 8) begin m_blink = 1; m_bcnt = 0; end
         end else if (tick) begin
            if (m_dwell < DWELL_MAX) m_dwell++;
            if (m_state == 8) begin
               m_bcnt++;
               if (m_bcnt == T_BLINK) begin m_bcnt = 0; m_blink = !m_blink; end
            end
         end
         m_state = nx;
      end
      e.ph = 4'(m_state);
      e.lm = tb_lamps(m_state, m_blink);
      e.rq = m_req;
      sb.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() == 0) begin
         check("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("phase", phase, e.ph);
         check("lamps", lamps_obs, e.lm);
         check("req_pending", req_pending, e.rq);
      end
      check("inv_green_both", green & green2, 0);
      check("inv_green_red2", green & ~red2, 0);
      check("inv_green2_red", green2 & ~red, 0);
      if (div3) tick = (cyc % 3 == 0);
   endtask

   // Number of consecutive cycles spent in ph, counting the current one.
   task automatic run_len(input logic [3:0] ph, output int n);
      n = 1;
      step();
      while (phase === ph && n < 300) begin
         n++;
         step();
      end
   endtask

   task automatic wait_phase(input logic [3:0] ph);
      int n;
      n = 0;
      while (phase !== ph && n < 200) begin
         step();
         n++;
      end
      check("reach_phase", phase, ph);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int n, g;
      logic [5:0] pat;
      rst = 1'b1; tick = 1'b1; req_b = 1'b0; night = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_phase", phase, 0);
      check("rst_lamps", lamps_obs, 6'b100_100);
      check("rst_req", req_pending, 0);

      // No request: A green holds indefinitely.
      step();
      check("rel_a_ry", phase, 1);
      step();
      check("rel_a_g", phase, 2);
      g = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (phase === 4'd2 && green === 1'b1 && red2 === 1'b1) g++;
      end
      check("ag_hold", g, 50);

      // Request pulse at A_G dwell 1, then full pass through B with req held.
      do_reset();
      step();
      step();
      step();
      req_b = 1'b1;
      step();
      req_b = 1'b0;
      check("req_latched", req_pending, 1);
      run_len(2, n);
      check("ag_len", 2 + n, T_GREEN_MIN);
      run_len(3, n);
      check("ay_len", n, T_YELLOW);
      run_len(4, n);
      check("arb_len", n, T_ALLRED);
      check("bry_entry", phase, 5);
      check("bry_req_clr", req_pending, 0);
      req_b = 1'b1;
      run_len(5, n);
      check("bry_len", n, T_RY);
      run_len(6, n);
      check("bg_len_max", n, T_GREEN_MAX);
      req_b = 1'b0;
      check("by_entry", phase, 7);
      check("b_req_not_latched", req_pending, 0);

      // req_b dropped at B_G dwell 2.
      wait_phase(2);
      req_b = 1'b1;
      step();
      req_b = 1'b0;
      wait_phase(5);
      req_b = 1'b1;
      wait_phase(6);
      step();
      step();
      req_b = 1'b0;
      run_len(6, n);
      check("bg_len_min", 2 + n, T_GREEN_MIN);

      // Night requested during A green with a pending request.
      do_reset();
      step();
      step();
      req_b = 1'b1; night = 1'b1;
      step();
      req_b = 1'b0;
      run_len(2, n);
      check("night_ag_len", 1 + n, T_GREEN_MIN);
      run_len(3, n);
      check("night_ay_len", n, T_YELLOW);
      run_len(4, n);
      check("night_arb_len", n, T_ALLRED);
      check("night_entry", phase, 8);
      pat = 6'b110011;
      for (int i = 0; i < 6; i++) begin
         check("night_y", yellow, pat[5-i]);
         check("night_y2", yellow2, pat[5-i]);
         check("night_reds", {red, red2}, 2'b00);
         step();
      end
      night = 1'b0;
      step();
      check("night_exit", phase, 0);

      // One tick every third cycle, then reset in the middle of B green.
      div3 = 1'b1;
      do_reset();
      req_b = 1'b1;
      step();
      req_b = 1'b0;
      wait_phase(1);
      run_len(1, n);
      check("x3_ary", n, 3 * T_RY);
      run_len(2, n);
      check("x3_ag", n, 3 * T_GREEN_MIN);
      run_len(3, n);
      check("x3_ay", n, 3 * T_YELLOW);
      run_len(4, n);
      check("x3_arb", n, 3 * T_ALLRED);
      run_len(5, n);
      check("x3_bry", n, 3 * T_RY);
      check("x3_bg", phase, 6);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midbg_rst_phase", phase, 0);
      check("midbg_rst_lamps", lamps_obs, 6'b100_100);
      check("midbg_rst_req", req_pending, 0);
      div3 = 1'b0;
      tick = 1'b1;

      // Random traffic with occasional resets.
      for (int i = 0; i < 10000; i++) begin
         tick  = ($urandom_range(0, 1) == 1);
         req_b = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 99) == 0) night = ~night;
         rst   = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 1'b0;
      check("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
